video_border_blanker: RTL and testbench

Downstream stage of the median filter. Tracks pixel position from AXI4-Stream video markers: tuser marks start of frame, tlast marks end of line. When enabled, it overwrites the border ring that the window filter cannot compute with a constant fill value. It also resynchronises to start of frame and flags malformed lines and frames; passes the stream at full throughput.

---
 rtl/video_blank_pkg.sv | 31 +++
 rtl/axi4_stream_skid_reg.sv | 53 +++++
 rtl/video_border_blanker.sv | 140 ++++++++++++++
 tb/tb_video_border_blanker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_blank_pkg.sv
// Shared types for the border blanker: FSM state, stream beat layout and
// the counter-width helper.
package video_blank_pkg;

    // Stream geometry the beat struct is laid out for.
    localparam int VB_TDATA_W = 32;
    localparam int VB_TDATA_B = 4;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } vb_state_e;

    typedef struct packed {
        logic [VB_TDATA_W-1:0] tdata;
        logic [VB_TDATA_B-1:0] tstrb;
        logic [VB_TDATA_B-1:0] tkeep;
        logic                  tlast;
        logic                  tuser;
        logic                  tid;
        logic                  tdest;
    } vb_beat_t;

    localparam int VB_BEAT_W = $bits(vb_beat_t);

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi4_stream_skid_reg.sv
// Two-entry register slice: one output register plus one skid register.
// Ready depends only on local state, so no combinational path crosses it.
module axi4_stream_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         live_q;
    logic         skid_vld;
    logic [W-1:0] skid_data;
    logic         in_acc;
    logic         out_free;

    // live_q keeps ready low while reset is asserted and for the first edge after.
    assign in_ready = live_q && !skid_vld;
    assign in_acc   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

    // Output register refills from skid first; skid catches a beat only during a stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            live_q    <= 1'b0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            live_q <= 1'b1;
            if (out_free) begin
                if (skid_vld) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                    skid_vld  <= 1'b0;
                end else begin
                    out_valid <= in_acc;
                    if (in_acc) out_data <= in_data;
                end
            end else if (in_acc) begin
                skid_vld  <= 1'b1;
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/video_border_blanker.sv
// Tracks pixel position from tuser/tlast, blanks the border ring with a
// fill value, resyncs on SOF and flags malformed lines/frames.
module video_border_blanker
    import video_blank_pkg::*;
#(
    parameter int PX_WIDTH        = 10,
    parameter int CHANNELS_AMOUNT = 3,
    parameter int TDATA_WIDTH     = 32,
    parameter int TDATA_WIDTH_B   = 4,
    parameter int FRAME_RES_X     = 1920,
    parameter int FRAME_RES_Y     = 1080,
    parameter int BORDER          = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_i,
    input  logic [PX_WIDTH-1:0]      fill_value_i,
    input  logic [TDATA_WIDTH-1:0]   video_i_tdata,
    input  logic [TDATA_WIDTH_B-1:0] video_i_tstrb,
    input  logic [TDATA_WIDTH_B-1:0] video_i_tkeep,
    input  logic                     video_i_tvalid,
    input  logic                     video_i_tlast,
    input  logic                     video_i_tuser,
    input  logic                     video_i_tid,
    input  logic                     video_i_tdest,
    output logic                     video_i_tready,
    output logic [TDATA_WIDTH-1:0]   video_o_tdata,
    output logic [TDATA_WIDTH_B-1:0] video_o_tstrb,
    output logic [TDATA_WIDTH_B-1:0] video_o_tkeep,
    output logic                     video_o_tvalid,
    output logic                     video_o_tlast,
    output logic                     video_o_tuser,
    output logic                     video_o_tid,
    output logic                     video_o_tdest,
    input  logic                     video_o_tready,
    output logic                     line_err_o,
    output logic                     frame_err_o,
    output logic                     drop_o
);

    localparam int X_W = cnt_w(FRAME_RES_X);
    localparam int Y_W = cnt_w(FRAME_RES_Y + 1);

    if (TDATA_WIDTH != VB_TDATA_W || TDATA_WIDTH_B != VB_TDATA_B) begin : g_width_check
        $error("video_border_blanker: stream widths must match vb_beat_t");
    end

    vb_state_e           state;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic                en_q;
    logic [PX_WIDTH-1:0] fill_q;

    logic                acc, sof, drop, x_last, line_end, frame_end, border, cur_en;
    logic [X_W-1:0]      cur_x;
    logic [Y_W-1:0]      cur_y;
    logic [PX_WIDTH-1:0] cur_fill;
    vb_beat_t            in_beat, blank_beat, out_beat;

    // An SOF beat is pixel (0,0) and uses the enable/fill sampled with it.
    assign acc       = video_i_tvalid && video_i_tready;
    assign sof       = video_i_tuser;
    assign drop      = acc && (state == WAIT_SOF) && !sof;
    assign cur_x     = sof ? '0 : x_q;
    assign cur_y     = sof ? '0 : y_q;
    assign cur_en    = sof ? en_i : en_q;
    assign cur_fill  = sof ? fill_value_i : fill_q;
    assign x_last    = (cur_x == X_W'(FRAME_RES_X - 1));
    assign line_end  = video_i_tlast || x_last;
    assign frame_end = line_end && (cur_y == Y_W'(FRAME_RES_Y - 1));
    assign border    = (int'(cur_x) < BORDER) || (int'(cur_x) >= FRAME_RES_X - BORDER) ||
                       (int'(cur_y) < BORDER) || (int'(cur_y) >= FRAME_RES_Y - BORDER);

    // A line error is either an early tlast or a missing tlast on the last column.
    assign line_err_o  = acc && !drop && line_end && !(x_last && video_i_tlast);
    assign frame_err_o = acc && (state == ACTIVE) && sof;
    assign drop_o      = drop;

    assign in_beat = '{tdata: video_i_tdata, tstrb: video_i_tstrb, tkeep: video_i_tkeep,
                       tlast: video_i_tlast, tuser: video_i_tuser, tid: video_i_tid,
                       tdest: video_i_tdest};

    // Overwrite every channel field of a border pixel; upper bits and sideband pass.
    always_comb begin
        blank_beat = in_beat;
        if (border && cur_en) begin
            for (int c = 0; c < CHANNELS_AMOUNT; c++) begin
                blank_beat.tdata[c*PX_WIDTH +: PX_WIDTH] = cur_fill;
            end
        end
    end

    // Position counters and frame state, advanced once per accepted pixel.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= WAIT_SOF;
            x_q    <= '0;
            y_q    <= '0;
            en_q   <= 1'b0;
            fill_q <= '0;
        end else if (acc && !drop) begin
            en_q   <= cur_en;
            fill_q <= cur_fill;
            if (line_end) begin
                x_q <= '0;
                if (frame_end) begin
                    y_q   <= '0;
                    state <= WAIT_SOF;
                end else begin
                    y_q   <= cur_y + 1'b1;
                    state <= ACTIVE;
                end
            end else begin
                x_q   <= cur_x + 1'b1;
                y_q   <= cur_y;
                state <= ACTIVE;
            end
        end
    end

    axi4_stream_skid_reg #(.W(VB_BEAT_W)) u_skid (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .in_data   (blank_beat),
        .in_valid  (video_i_tvalid && !((state == WAIT_SOF) && !sof)),
        .in_ready  (video_i_tready),
        .out_data  (out_beat),
        .out_valid (video_o_tvalid),
        .out_ready (video_o_tready)
    );

    assign video_o_tdata = out_beat.tdata;
    assign video_o_tstrb = out_beat.tstrb;
    assign video_o_tkeep = out_beat.tkeep;
    assign video_o_tlast = out_beat.tlast;
    assign video_o_tuser = out_beat.tuser;
    assign video_o_tid   = out_beat.tid;
    assign video_o_tdest = out_beat.tdest;

endmodule

// File: tb/tb_video_border_blanker.sv
// Bench for video_border_blanker on an 8x4 frame: a position/blanking model
// predicts every output beat and every error pulse.
module tb_video_border_blanker;

    localparam int RX = 8;
    localparam int RY = 4;
    localparam int BD = 1;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  k;
        logic        l, u, i, de;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [9:0]  fill = '0;
    logic [31:0] vi_tdata = '0;
    logic [3:0]  vi_tstrb = '0, vi_tkeep = '0;
    logic        vi_tvalid = 1'b0, vi_tlast = 1'b0, vi_tuser = 1'b0, vi_tid = 1'b0, vi_tdest = 1'b0;
    logic        vi_tready;
    logic [31:0] vo_tdata;
    logic [3:0]  vo_tstrb, vo_tkeep;
    logic        vo_tvalid, vo_tlast, vo_tuser, vo_tid, vo_tdest;
    logic        vo_tready = 1'b1;
    logic        line_err, frame_err, drop;

    always #5 clk = ~clk;

    video_border_blanker #(.FRAME_RES_X(RX), .FRAME_RES_Y(RY), .BORDER(BD)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .fill_value_i(fill),
        .video_i_tdata(vi_tdata), .video_i_tstrb(vi_tstrb), .video_i_tkeep(vi_tkeep),
        .video_i_tvalid(vi_tvalid), .video_i_tlast(vi_tlast), .video_i_tuser(vi_tuser),
        .video_i_tid(vi_tid), .video_i_tdest(vi_tdest), .video_i_tready(vi_tready),
        .video_o_tdata(vo_tdata), .video_o_tstrb(vo_tstrb), .video_o_tkeep(vo_tkeep),
        .video_o_tvalid(vo_tvalid), .video_o_tlast(vo_tlast), .video_o_tuser(vo_tuser),
        .video_o_tid(vo_tid), .video_o_tdest(vo_tdest), .video_o_tready(vo_tready),
        .line_err_o(line_err), .frame_err_o(frame_err), .drop_o(drop)
    );

    int    n_vec = 0, n_err = 0;
    int    cnt_drop = 0, cnt_le = 0, cnt_fe = 0, out_cnt = 0, cyc = 0;
    bit    rnd_rdy = 1'b0, rnd_ctl = 1'b0;
    beat_t exp_q[$];
    beat_t log_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ramp(input int i);
        logic [9:0] v;
        v = 10'(i);
        return {2'b10, v, v, v};
    endfunction

    // Reference model: beat position, border test and latched controls in plain integers.
    bit         m_act = 1'b0, m_en = 1'b0, prev_stall = 1'b0;
    int         m_x = 0, m_y = 0;
    logic [9:0] m_fill = '0;
    beat_t      prev_beat;

    always @(negedge clk) begin
        beat_t ob, eb, ib;
        bit e_le, e_fe, e_dr;
        cyc++;
        ob = {vo_tdata, vo_tstrb, vo_tkeep, vo_tlast, vo_tuser, vo_tid, vo_tdest};
        if (!rst_n) begin
            exp_q.delete();
            m_act = 1'b0; m_x = 0; m_y = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", vo_tvalid, 1'b1);
                chk("hold_payload", ob, prev_beat);
            end
            if (vo_tvalid && vo_tready) begin
                out_cnt++;
                log_q.push_back(ob);
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL out_extra: got beat %0h expected no beat", ob);
                end else begin
                    eb = exp_q.pop_front();
                    chk("out_beat", ob, eb);
                end
            end
            prev_stall = vo_tvalid && !vo_tready;
            prev_beat  = ob;

            e_le = 1'b0; e_fe = 1'b0; e_dr = 1'b0;
            if (vi_tvalid && vi_tready) begin
                if (!m_act && !vi_tuser) begin
                    e_dr = 1'b1;
                end else begin
                    if (vi_tuser) begin
                        e_fe = m_act;
                        m_act = 1'b1; m_x = 0; m_y = 0;
                        m_en = en; m_fill = fill;
                    end
                    ib = {vi_tdata, vi_tstrb, vi_tkeep, vi_tlast, vi_tuser, vi_tid, vi_tdest};
                    if (m_en && (m_x < BD || m_x >= RX - BD || m_y < BD || m_y >= RY - BD))
                        ib.d = {vi_tdata[31:30], m_fill, m_fill, m_fill};
                    exp_q.push_back(ib);
                    if (vi_tlast || m_x == RX - 1) begin
                        e_le = !(vi_tlast && m_x == RX - 1);
                        m_x = 0;
                        m_y++;
                        if (m_y == RY) begin m_y = 0; m_act = 1'b0; end
                    end else begin
                        m_x++;
                    end
                end
            end
            chk("line_err", line_err, e_le);
            chk("frame_err", frame_err, e_fe);
            chk("drop", drop, e_dr);
            cnt_le   += int'(line_err);
            cnt_fe   += int'(frame_err);
            cnt_drop += int'(drop);
        end
    end

    // Output back-pressure: always ready, or 50% random.
    always @(posedge clk) begin
        #1;
        vo_tready = rnd_rdy ? 1'($urandom) : 1'b1;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int idx, input bit u, input bit l);
        int t;
        t = 0;
        if (rnd_ctl) begin
            en   = 1'($urandom);
            fill = 10'($urandom);
        end
        vi_tdata = ramp(idx); vi_tuser = u; vi_tlast = l;
        vi_tstrb = 4'($urandom); vi_tkeep = 4'($urandom);
        vi_tid = 1'($urandom); vi_tdest = 1'($urandom);
        vi_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (vi_tready) break;
            t++;
            if (t > 200) begin
                n_vec++; n_err++;
                $display("FAIL send_timeout: beat %0d got no tready in 200 cycles, expected acceptance", idx);
                break;
            end
        end
        @(posedge clk); #1;
        vi_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int y = 0; y < RY; y++)
            for (int x = 0; x < RX; x++) begin
                send(base + y*RX + x, (x == 0 && y == 0), (x == RX - 1));
                if (gaps) idle($urandom_range(0, 2));
            end
    endtask

    initial begin
        int k0, c0, d0, le0, fe0;
        #2;
        chk("rst_tready", vi_tready, 1'b0);
        chk("rst_tvalid", vo_tvalid, 1'b0);
        chk("rst_tdata", vo_tdata, 32'h0);
        chk("rst_pulses", {line_err, frame_err, drop}, 3'b000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Blanked 8x4 frame at full rate.
        en = 1'b1; fill = 10'h3FF;
        log_q.delete();
        k0 = cyc; c0 = out_cnt;
        send_frame(0, 1'b0);
        chk("latency_before_last", out_cnt - c0, 31);
        @(negedge clk); #1;
        chk("beats_out", out_cnt - c0, 32);
        chk("cycles", cyc - k0, 33);
        chk("px_0_0", log_q[0].d, 32'hBFFFFFFF);
        chk("px_1_1", log_q[9].d, 32'h80902409);
        chk("px_6_1", log_q[14].d, 32'h80E0380E);
        chk("px_7_1", log_q[15].d, 32'hBFFFFFFF);
        chk("px_0_3", log_q[24].d, 32'hBFFFFFFF);
        idle(1);

        // Blanking disabled: pass-through, no errors.
        en = 1'b0;
        log_q.delete();
        le0 = cnt_le; fe0 = cnt_fe;
        send_frame(0, 1'b0);
        idle(2);
        chk("noblank_px_0_0", log_q[0].d, 32'h80000000);
        chk("noblank_errs", (cnt_le - le0) + (cnt_fe - fe0), 0);

        // Five beats before SOF are discarded.
        en = 1'b1;
        log_q.delete();
        d0 = cnt_drop;
        for (int i = 0; i < 5; i++) send(100 + i, 1'b0, 1'b0);
        send_frame(0, 1'b0);
        idle(2);
        chk("drop_count", cnt_drop - d0, 5);
        chk("first_out_sof", log_q[0].u, 1'b1);
        chk("frame_beats", log_q.size(), 32);

        // Short line 1, long line 2 spilling into line 3.
        log_q.delete();
        le0 = cnt_le; d0 = cnt_drop;
        for (int i = 0; i < 8; i++) send(i, i == 0, i == 7);
        for (int i = 8; i < 14; i++) send(i, 1'b0, i == 13);
        for (int i = 14; i < 23; i++) send(i, 1'b0, 1'b0);
        for (int i = 23; i < 30; i++) send(i, 1'b0, i == 29);
        send(30, 1'b0, 1'b0);
        idle(2);
        chk("line_err_count", cnt_le - le0, 2);
        chk("post_frame_drop", cnt_drop - d0, 1);
        chk("px_3_2", log_q[17].d, 32'h81104411);

        // SOF at pixel (3,2) restarts the frame.
        fill = 10'h155;
        log_q.delete();
        fe0 = cnt_fe; le0 = cnt_le;
        for (int i = 0; i < 19; i++) send(i, i == 0, (i % 8) == 7);
        send_frame(19, 1'b0);
        idle(2);
        chk("frame_err_count", cnt_fe - fe0, 1);
        chk("restart_px_blank", log_q[19].d[29:0], 30'h15555555);
        chk("restart_no_line_err", cnt_le - le0, 0);

        // Random back-pressure, random gaps, controls toggling mid-frame.
        rnd_rdy = 1'b1; rnd_ctl = 1'b1;
        c0 = out_cnt;
        for (int f = 0; f < 3; f++) send_frame(f * 32, 1'b1);
        rnd_rdy = 1'b0; rnd_ctl = 1'b0;
        idle(4);
        chk("random_beats", out_cnt - c0, 96);

        // Reset mid-line abandons the in-flight beat.
        en = 1'b1; fill = 10'h3FF;
        for (int i = 0; i < 4; i++) send(i, i == 0, 1'b0);
        chk("pre_reset_valid", vo_tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", vo_tvalid, 1'b0);
        chk("mid_rst_tready", vi_tready, 1'b0);
        chk("mid_rst_pulses", {line_err, frame_err, drop}, 3'b000);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);
        d0 = cnt_drop;
        send(50, 1'b0, 1'b0);
        chk("post_reset_drop", cnt_drop - d0, 1);
        c0 = out_cnt;
        send_frame(0, 1'b0);
        idle(3);
        chk("post_reset_frame", out_cnt - c0, 32);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
